lcd_bus_scheduler: RTL and testbench



---
 rtl/lcd_bus_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_lcd_bus_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_bus_scheduler
//
// Shares the 4-bit character-LCD bus between two instruction sources.
// Requester 0 is the initialization path and requester 1 is the runtime write
// path. One 10-bit instruction {RS,RW,D[7:0]} is latched per transaction and
// played out as an upper-nibble E pulse, a gap, a lower-nibble E pulse and the
// post-command execution wait.
//
// Optional feature: define ROUND_ROBIN_EN to alternate grants between the two
// requesters under contention (a last_grant register, reset to 1). With the
// macro undefined, requester 0 always has priority.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   reqN_valid / reqN_instr  instruction offered by requester N
//   reqN_ready               combinational accept; transfer on valid & ready
//   busy                     registered, high while a transaction runs
//   done                     registered one-cycle pulse on the first IDLE cycle
//   grant_id                 requester owning the current/last transaction
//   LCD_E, LCD_RS, LCD_RW    registered LCD control pins
//   SF_D                     registered LCD data nibble
//
// Handshake: reqN_ready depends only on the current state (and, for
// arbitration, the other requester's valid). A transfer happens on a clock edge
// where reqN_valid & reqN_ready are both high; the requester must hold valid
// and instr stable until then. Nothing is queued.
// -----------------------------------------------------------------------------
module lcd_bus_scheduler #(
    parameter int SETUP_CYC  = 2,
    parameter int E_CYC      = 12,
    parameter int NIBBLE_GAP = 50,
    parameter int CMD_WAIT   = 2000,
    parameter int LONG_WAIT  = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [9:0] req0_instr,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [9:0] req1_instr,
    output logic       req1_ready,
    output logic       busy,
    output logic       done,
    output logic       grant_id,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [3:0] SF_D
);

    localparam int CW = 17;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_U_SETUP = 4'd1;
    localparam logic [3:0] S_U_E     = 4'd2;
    localparam logic [3:0] S_U_HOLD  = 4'd3;
    localparam logic [3:0] S_GAP     = 4'd4;
    localparam logic [3:0] S_L_SETUP = 4'd5;
    localparam logic [3:0] S_L_E     = 4'd6;
    localparam logic [3:0] S_L_HOLD  = 4'd7;
    localparam logic [3:0] S_WAIT    = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    instr_q, instr_d;
    logic          grant_id_q, grant_id_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          lcd_e_q, lcd_e_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          lcd_rw_q, lcd_rw_d;
    logic [3:0]    sf_d_q, sf_d_d;

    logic idle;
    logic accept;
    logic accept_id;
    logic is_long;

    assign idle = (state_q == S_IDLE);

    // Clear Display (0x01) and Return Home (0x02/0x03) need the long wait.
    assign is_long = ~instr_q[9] &
                     ((instr_q[7:0] == 8'h01) | (instr_q[7:1] == 7'h01));

    // Counter value loaded on entry to a state: the state lasts load+1 cycles.
    function automatic logic [CW-1:0] load_val(input logic [3:0] st,
                                               input logic       long_w);
        case (st)
            S_U_SETUP, S_L_SETUP: load_val = CW'(SETUP_CYC - 1);
            S_U_E, S_L_E:         load_val = CW'(E_CYC - 1);
            S_GAP:                load_val = CW'(NIBBLE_GAP - 1);
            S_WAIT:               load_val = long_w ? CW'(LONG_WAIT - 1)
                                                    : CW'(CMD_WAIT - 1);
            default:              load_val = '0;
        endcase
    endfunction

`ifdef ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // Under contention the requester that did not win last time is served.
    assign req0_ready = idle & (~req1_valid | last_grant_q);
    assign req1_ready = idle & (~req0_valid | ~last_grant_q);

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = accept_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign req0_ready = idle;
    assign req1_ready = idle & ~req0_valid;
`endif

    // Arbitration and sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        grant_id_d = grant_id_q;
        accept     = 1'b0;
        accept_id  = 1'b0;
        if (idle) begin
            if (req0_valid && req0_ready) begin
                accept  = 1'b1;
                instr_d = req0_instr;
            end else if (req1_valid && req1_ready) begin
                accept    = 1'b1;
                accept_id = 1'b1;
                instr_d   = req1_instr;
            end
            if (accept) begin
                grant_id_d = accept_id;
                state_d    = S_U_SETUP;
                cnt_d      = load_val(S_U_SETUP, 1'b0);
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            case (state_q)
                S_U_SETUP: state_d = S_U_E;
                S_U_E:     state_d = S_U_HOLD;
                S_U_HOLD:  state_d = S_GAP;
                S_GAP:     state_d = S_L_SETUP;
                S_L_SETUP: state_d = S_L_E;
                S_L_E:     state_d = S_L_HOLD;
                S_L_HOLD:  state_d = S_WAIT;
                default:   state_d = S_IDLE;
            endcase
            cnt_d = load_val(state_d, is_long);
        end
    end

    // Pin values are decoded from the next state so they are registered and
    // line up with the state they belong to.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_q == S_WAIT) && (state_d == S_IDLE);
        lcd_e_d  = (state_d == S_U_E) || (state_d == S_L_E);
        lcd_rs_d = busy_d & instr_d[9];
        lcd_rw_d = busy_d & instr_d[8];
        case (state_d)
            S_U_SETUP, S_U_E, S_U_HOLD, S_GAP:     sf_d_d = instr_d[7:4];
            S_L_SETUP, S_L_E, S_L_HOLD, S_WAIT:    sf_d_d = instr_d[3:0];
            default:                               sf_d_d = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            instr_q    <= '0;
            grant_id_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_rw_q   <= 1'b0;
            sf_d_q     <= 4'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_rw_q   <= lcd_rw_d;
            sf_d_q     <= sf_d_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign grant_id = grant_id_q;
    assign LCD_E    = lcd_e_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_RW   = lcd_rw_q;
    assign SF_D     = sf_d_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_scheduler
//
// Bench for lcd_bus_scheduler with shortened timing parameters so that long
// waits stay cheap: SETUP=2, E=3, GAP=5, CMD_WAIT=20, LONG_WAIT=60.
// Busy length is 2*(2+3+1)+5+wait = 37 (command) or 77 (long wait); done
// shows on the cycle after the last busy cycle.
// -----------------------------------------------------------------------------
module tb_lcd_bus_scheduler;

    localparam int SETUP = 2;
    localparam int ECYC  = 3;
    localparam int GAP   = 5;
    localparam int CMDW  = 20;
    localparam int LONGW = 60;
    // Busy offset where the lower nibble phase begins, and where WAIT begins.
    localparam int LOFF  = SETUP + ECYC + 1 + GAP;
    localparam int WOFF  = LOFF + SETUP + ECYC + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       req0_valid, req1_valid;
    logic [9:0] req0_instr, req1_instr;
    logic       req0_ready, req1_ready;
    logic       busy, done, grant_id;
    logic       LCD_E, LCD_RS, LCD_RW;
    logic [3:0] SF_D;

    lcd_bus_scheduler #(
        .SETUP_CYC (SETUP),
        .E_CYC     (ECYC),
        .NIBBLE_GAP(GAP),
        .CMD_WAIT  (CMDW),
        .LONG_WAIT (LONGW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_instr(req0_instr),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_instr(req1_instr),
        .req1_ready(req1_ready),
        .busy      (busy),
        .done      (done),
        .grant_id  (grant_id),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .SF_D      (SF_D)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int blen(input logic [9:0] ins);
        bit lng;
        lng = !ins[9] && (ins[7:0] == 8'h01 || ins[7:0] == 8'h02 || ins[7:0] == 8'h03);
        return 2 * (SETUP + ECYC + 1) + GAP + (lng ? LONGW : CMDW);
    endfunction

    // Model of the transaction in flight: start cycle, length, instruction.
    bit         m_act = 0;
    int         m_start = 0;
    int         m_len = 0;
    logic [9:0] m_instr = '0;
    logic       m_grant = 1'b0;
    logic       m_lg = 1'b1;
    int         acc_cnt[2] = '{0, 0};
    int         acc_log[$];
    bit         grant_log[$];
    logic [4:0] exp_q[$];   // expected {RS, nibble} per E rising edge
    logic       prev_e = 1'b0;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int k;
        bit eb, ed, idle, ee, er0, er1, a0, a1;
        logic [3:0] es;
        if (cyc >= 1) begin
            k    = cyc - m_start;
            eb   = m_act && k >= 0 && k < m_len;
            ed   = m_act && k == m_len;
            idle = !eb;
            ee   = eb && ((k >= SETUP && k < SETUP + ECYC) ||
                          (k >= LOFF + SETUP && k < LOFF + SETUP + ECYC));
            es   = !eb ? 4'h0 : (k < LOFF ? m_instr[7:4] : m_instr[3:0]);
`ifdef ROUND_ROBIN_EN
            er0 = idle && (!req1_valid || m_lg);
            er1 = idle && (!req0_valid || !m_lg);
`else
            er0 = idle;
            er1 = idle && !req0_valid;
`endif
            check("busy", busy, eb);
            check("done", done, ed);
            check("lcd_e", LCD_E, ee);
            check("lcd_rs", LCD_RS, eb & m_instr[9]);
            check("lcd_rw", LCD_RW, eb & m_instr[8]);
            check("grant_id", grant_id, m_grant);
            check("req0_ready", req0_ready, er0);
            check("req1_ready", req1_ready, er1);
            if (!(eb && k >= WOFF)) check("sf_d", SF_D, es);

            if (LCD_E === 1'b1 && prev_e === 1'b0) begin
                if (exp_q.size() == 0) check("nibble_unexpected", 1, 0);
                else check("nibble", {LCD_RS, SF_D}, exp_q.pop_front());
            end
            prev_e = LCD_E;

            if (reset) begin
                m_act   = 0;
                m_grant = 1'b0;
                m_lg    = 1'b1;
                exp_q.delete();
            end else begin
                a0 = req0_valid && er0;
                a1 = req1_valid && er1 && !a0;
                if (a0 || a1) begin
                    m_instr = a0 ? req0_instr : req1_instr;
                    m_act   = 1;
                    m_start = cyc + 1;
                    m_len   = blen(m_instr);
                    m_grant = a1;
                    m_lg    = a1;
                    exp_q.push_back({m_instr[9], m_instr[7:4]});
                    exp_q.push_back({m_instr[9], m_instr[3:0]});
                    acc_cnt[a1] = acc_cnt[a1] + 1;
                    acc_log.push_back(cyc);
                    grant_log.push_back(a1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction and hold it until accepted; keep leaves valid high.
    task automatic drive(input int id, input logic [9:0] instr, input bit keep);
        int start;
        bit got;
        align();
        start = acc_cnt[id];
        got   = 0;
        if (id == 0) begin req0_valid = 1'b1; req0_instr = instr; end
        else         begin req1_valid = 1'b1; req1_instr = instr; end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (acc_cnt[id] != start) begin got = 1; break; end
        end
        check("accept_timeout", got, 1);
        align();
        if (!keep) begin
            if (id == 0) req0_valid = 1'b0;
            else         req1_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin ok = 1; break; end
        end
        check("idle_timeout", ok, 1);
    endtask

    // Watch one transaction from just after accept to its done pulse.
    task automatic measure(output int r1, output int r2, output int h1, output int dn,
                           output logic [3:0] n1, output logic [3:0] n2, output logic rs);
        logic pe;
        pe = 1'b0; r1 = -1; r2 = -1; h1 = 0; dn = -1; n1 = 4'h0; n2 = 4'h0; rs = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (LCD_E && !pe) begin
                if (r1 < 0)      begin r1 = cyc; n1 = SF_D; rs = LCD_RS; end
                else if (r2 < 0) begin r2 = cyc; n2 = SF_D; end
            end
            if (LCD_E && r1 >= 0 && r2 < 0) h1++;
            pe = LCD_E;
            if (done) begin dn = cyc; break; end
        end
        check("measure_done_seen", (dn >= 0), 1);
    endtask

    task automatic do_reset();
        align();
        reset = 1'b1;
        repeat (2) align();
        reset = 1'b0;
    endtask

    function automatic logic [9:0] rand_instr();
        logic [9:0] v;
        case ($urandom_range(0, 4))
            0: v = 10'h001;
            1: v = 10'h002;
            2: v = 10'h003;
            default: v = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255))};
        endcase
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int a, r1, r2, h1, dn, c1, d, pat;
        logic [3:0] n1, n2;
        logic rs;
        logic [9:0] i0, i1;
        logic [9:0] long_list[4];
        int exp_order[4];

        req0_valid = 1'b0; req0_instr = '0;
        req1_valid = 1'b0; req1_instr = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_lcd_e", LCD_E, 0);
        check("rst_sf_d", SF_D, 0);
        check("rst_grant", grant_id, 0);
        check("rst_req0_ready", req0_ready, 1);

        // Single write 'A' from requester 1.
        drive(1, 10'h241, 0);
        a = acc_log[$];
        measure(r1, r2, h1, dn, n1, n2, rs);
        check("a_first_rise", r1 - a, 3);
        check("a_e_high_len", h1, 3);
        check("a_lower_rise_gap", r2 - r1, 11);
        check("a_done_latency", dn - a, 38);
        check("a_upper_nib", n1, 4'h4);
        check("a_lower_nib", n2, 4'h1);
        check("a_rs", rs, 1);

        // Clear Display / Return Home variants and a normal command.
        long_list = '{10'h001, 10'h002, 10'h003, 10'h028};
        for (int i = 0; i < 4; i++) begin
            drive(0, long_list[i], 0);
            a = acc_log[$];
            measure(r1, r2, h1, dn, n1, n2, rs);
            check("cmd_done_latency", dn - a, (i == 3) ? 38 : 78);
            check("cmd_rs", rs, 0);
            if (i == 0) begin
                check("clr_upper_nib", n1, 4'h0);
                check("clr_lower_nib", n2, 4'h1);
            end
        end

        // Contention: both requesters hold two instructions each.
        do_reset();
        grant_log.delete();
        acc_log.delete();
        fork
            begin drive(0, 10'h230, 1); drive(0, 10'h231, 0); end
            begin drive(1, 10'h250, 1); drive(1, 10'h251, 0); end
        join
        wait_idle();
`ifdef ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        check("cont_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("cont_order", grant_log[i], exp_order[i]);
            for (int i = 0; i < 3; i++) check("cont_accept_gap", acc_log[i+1] - acc_log[i], 38);
        end

        // Reset during the upper E pulse.
        drive(0, 10'h028, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (LCD_E) break;
        end
        check("pre_reset_e_high", LCD_E, 1);
        align();
        reset = 1'b1;
        align();
        reset = 1'b0;
        check("midrst_lcd_e", LCD_E, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sf_d", SF_D, 0);
        check("midrst_done", done, 0);
        align();
        check("postrst_req0_ready", req0_ready, 1);
        check("postrst_done", done, 0);

        // Back-to-back from requester 1 with valid held throughout.
        acc_log.delete();
        c1 = acc_cnt[1];
        drive(1, 10'h248, 1);
        drive(1, 10'h265, 1);
        drive(1, 10'h26C, 0);
        wait_idle();
        check("b2b_accepts", acc_cnt[1] - c1, 3);
        if (acc_log.size() == 3) begin
            check("b2b_gap0", acc_log[1] - acc_log[0], 38);
            check("b2b_gap1", acc_log[2] - acc_log[1], 38);
        end

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            pat = $urandom_range(0, 3);
            i0  = rand_instr();
            i1  = rand_instr();
            case (pat)
                0: drive(0, i0, 0);
                1: drive(1, i1, 0);
                2: fork drive(0, i0, 0); drive(1, i1, 0); join
                default: begin
                    d = $urandom_range(1, 40);
                    fork
                        drive(0, i0, 0);
                        begin repeat (d) @(posedge clk); drive(1, i1, 0); end
                    join
                end
            endcase
            if ($urandom_range(0, 1) == 1) wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        wait_idle();
        repeat (3) @(posedge clk);
        check("nibble_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
